// File: rtl/cache_line_mem.sv
// cache_line_mem: 256 x 128-bit backing store for the L1 cache with
// byte-masked writes, a fixed programmable latency per direction and one
// transaction in flight at a time.
//
// Handshake semantics (every channel): a transfer happens on the rising
// edge where valid and ready are both 1. A producer holds its payload
// stable while valid is 1 and ready is 0. Request inputs are ignored on any
// edge where the matching ready is 0. Response payloads stay stable until
// they are taken.

package cache_pkg;

  // Read request: line address (tag,index).
  typedef struct packed {
    logic [7:0] addr;
  } mem_r_req_bus_t;

  // Read response: line data plus status.
  typedef struct packed {
    logic [127:0] rdata;
    logic [1:0]   rresp;
  } mem_r_resp_bus_t;

  // Write request: line address, line data and per-byte enables.
  typedef struct packed {
    logic [7:0]   addr;
    logic [127:0] data;
    logic [15:0]  wmask;
  } mem_w_req_bus_t;

  // Write completion status.
  typedef struct packed {
    logic [1:0] bresp;
  } mem_w_resp_bus_t;

  // Controller states, exported so checkers can observe the FSM.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR_RESP = 3'd4
  } clm_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

module cache_line_mem
  import cache_pkg::*;
#(
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            rd_req_valid,
  output logic            rd_req_ready,
  input  mem_r_req_bus_t  rd_req,

  output logic            rd_resp_valid,
  input  logic            rd_resp_ready,
  output mem_r_resp_bus_t rd_resp,

  input  logic            wr_req_valid,
  output logic            wr_req_ready,
  input  mem_w_req_bus_t  wr_req,

  output logic            wr_resp_valid,
  input  logic            wr_resp_ready,
  output mem_w_resp_bus_t wr_resp,

  output clm_state_e      dbg_state
);

  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  // Counter load values: the wait state is entered on the accept edge and
  // the final wait edge is the one where the counter reads zero.
  localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WR_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Line storage; deliberately not reset.
  logic [127:0] mem [256];

  clm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, addr_d;
  logic [127:0]     data_q, data_d;
  logic [15:0]      wmask_q, wmask_d;
  logic [127:0]     rdata_q, rdata_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_valid_q, wr_valid_d;

  logic [127:0]     mem_line;
  logic [127:0]     wr_line;
  logic             mem_we;
  logic             rd_accept;
  logic             wr_accept;

  // Request readiness: only IDLE accepts, and a pending write blocks the
  // read so a dirty write-back always lands before its refill.
  assign wr_req_ready = (state_q == ST_IDLE);
  assign rd_req_ready = (state_q == ST_IDLE) && !wr_req_valid;

  assign wr_accept = wr_req_valid && wr_req_ready;
  assign rd_accept = rd_req_valid && rd_req_ready;

  // Current content of the latched line, used by both read and merge.
  assign mem_line = mem[addr_q];

  // Byte merge: masked-in bytes come from the request, the rest keep the
  // stored value, so wmask == 0 rewrites the line unchanged.
  always_comb begin
    wr_line = mem_line;
    for (int i = 0; i < 16; i++) begin
      if (wmask_q[i]) begin
        wr_line[i*8 +: 8] = data_q[i*8 +: 8];
      end
    end
  end

  // Next-state and datapath update for the single-transaction controller.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    rd_valid_d = rd_valid_q;
    wr_valid_d = wr_valid_q;
    mem_we     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (wr_accept) begin
          addr_d  = wr_req.addr;
          data_d  = wr_req.data;
          wmask_d = wr_req.wmask;
          cnt_d   = WR_CNT_INIT;
          state_d = ST_WR_WAIT;
        end else if (rd_accept) begin
          addr_d  = rd_req.addr;
          cnt_d   = RD_CNT_INIT;
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d    = mem_line;
          rd_valid_d = 1'b1;
          state_d    = ST_RD_RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_RD_RESP: begin
        if (rd_resp_ready) begin
          rd_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      ST_WR_WAIT: begin
        if (cnt_q == '0) begin
          mem_we     = 1'b1;
          wr_valid_d = 1'b1;
          state_d    = ST_WR_RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_WR_RESP: begin
        if (wr_resp_ready) begin
          wr_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        rd_valid_d = 1'b0;
        wr_valid_d = 1'b0;
        cnt_d      = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // Controller registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
    end
  end

  // Array write on the final wait edge; reset forces IDLE asynchronously,
  // so a write still waiting when reset arrives is never committed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wr_line;
    end
  end

  assign rd_resp_valid = rd_valid_q;
  assign rd_resp.rdata = rdata_q;
  assign rd_resp.rresp = RESP_OKAY;

  assign wr_resp_valid = wr_valid_q;
  assign wr_resp.bresp = RESP_OKAY;

  assign dbg_state = state_q;

  // At most one response channel is active, matching the single
  // outstanding transaction.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(rd_valid_q && wr_valid_q));

  // Response valids only ever appear in their response states.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (rd_valid_q == (state_q == ST_RD_RESP)) &&
                   (wr_valid_q == (state_q == ST_WR_RESP)));

endmodule

// File: tb/tb_cache_line_mem.sv
// Directed bench for cache_line_mem: drivers issue requests and push the
// hand-computed responses and their arrival cycles into queues; a monitor
// pops and compares whenever a response appears.
module tb_cache_line_mem;
  import cache_pkg::*;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            rd_req_valid = 1'b0;
  logic            rd_req_ready;
  mem_r_req_bus_t  rd_req = '0;
  logic            rd_resp_valid;
  logic            rd_resp_ready = 1'b1;
  mem_r_resp_bus_t rd_resp;
  logic            wr_req_valid = 1'b0;
  logic            wr_req_ready;
  mem_w_req_bus_t  wr_req = '0;
  logic            wr_resp_valid;
  logic            wr_resp_ready = 1'b1;
  mem_w_resp_bus_t wr_resp;
  clm_state_e      dbg_state;

  cache_line_mem #(.RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req       (rd_req),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_ready(rd_resp_ready),
    .rd_resp      (rd_resp),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_req       (wr_req),
    .wr_resp_valid(wr_resp_valid),
    .wr_resp_ready(wr_resp_ready),
    .wr_resp      (wr_resp),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [129:0] exp_rd_q[$];
  int           exp_rd_cyc_q[$];
  logic [1:0]   exp_wr_q[$];
  int           exp_wr_cyc_q[$];

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: samples mid-cycle, away from the active edge.
  logic         rd_seen = 1'b0;
  logic         wr_seen = 1'b0;
  logic [129:0] cur_rd = '0;
  always @(negedge clk) begin
    #2;
    if (rd_resp_valid) begin
      if (!rd_seen) begin
        if (exp_rd_q.size() == 0) begin
          check("rd_resp_unexpected", 130'(rd_resp_valid), 130'(0));
        end else begin
          cur_rd = exp_rd_q.pop_front();
          check("rd_data", rd_resp, cur_rd);
          check("rd_latency", 130'(cyc), 130'(exp_rd_cyc_q.pop_front()));
        end
      end else begin
        check("rd_hold", rd_resp, cur_rd);
      end
      rd_seen = !rd_resp_ready;
    end else begin
      rd_seen = 1'b0;
    end

    if (wr_resp_valid) begin
      if (!wr_seen) begin
        if (exp_wr_q.size() == 0) begin
          check("wr_resp_unexpected", 130'(wr_resp_valid), 130'(0));
        end else begin
          check("wr_bresp", 130'(wr_resp), 130'(exp_wr_q.pop_front()));
          check("wr_latency", 130'(cyc), 130'(exp_wr_cyc_q.pop_front()));
        end
      end
      wr_seen = !wr_resp_ready;
    end else begin
      wr_seen = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_wr_accept(output int acc);
    int n = 0;
    acc = -1;
    #1;
    while (!wr_req_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!wr_req_ready) begin
      fail_now("wr_accept_timeout");
    end else begin
      @(posedge clk); #1;
      acc = cyc;
      exp_wr_q.push_back(RESP_OKAY);
      exp_wr_cyc_q.push_back(acc + WR_LAT);
    end
    @(negedge clk);
    wr_req_valid = 1'b0;
  endtask

  task automatic wait_rd_accept(input logic [127:0] exp_data, output int acc);
    int n = 0;
    acc = -1;
    #1;
    while (!rd_req_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!rd_req_ready) begin
      fail_now("rd_accept_timeout");
    end else begin
      @(posedge clk); #1;
      acc = cyc;
      exp_rd_q.push_back({exp_data, RESP_OKAY});
      exp_rd_cyc_q.push_back(acc + RD_LAT);
    end
    @(negedge clk);
    rd_req_valid = 1'b0;
  endtask

  task automatic send_wr(input logic [7:0] a, input logic [127:0] d, input logic [15:0] m,
                         output int acc);
    @(negedge clk);
    wr_req_valid = 1'b1;
    wr_req.addr  = a;
    wr_req.data  = d;
    wr_req.wmask = m;
    wait_wr_accept(acc);
  endtask

  task automatic send_rd(input logic [7:0] a, input logic [127:0] exp_data, output int acc);
    @(negedge clk);
    rd_req_valid = 1'b1;
    rd_req.addr  = a;
    wait_rd_accept(exp_data, acc);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_rd_q.size() != 0 || exp_wr_q.size() != 0) && n < 100) begin
      @(negedge clk); n++;
    end
    if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_rd_q.delete(); exp_rd_cyc_q.delete();
      exp_wr_q.delete(); exp_wr_cyc_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  localparam logic [127:0] FULL_DATA = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] PRIO_DATA = 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678;
  localparam logic [127:0] BP_DATA   = 128'h0F0E0D0C0B0A0908_0706050403020100;

  int acc_w;
  int acc_r;

  initial begin
    // Reset state, checked while reset is asserted.
    #1 rst_n = 1'b0;
    #2;
    check("rst_wr_req_ready", 130'(wr_req_ready), 130'(1));
    check("rst_rd_req_ready_idle", 130'(rd_req_ready), 130'(1));
    check("rst_rd_resp_valid", 130'(rd_resp_valid), 130'(0));
    check("rst_wr_resp_valid", 130'(wr_resp_valid), 130'(0));
    check("rst_rd_resp", rd_resp, 130'(0));
    check("rst_wr_resp", 130'(wr_resp), 130'(0));
    wr_req_valid = 1'b1;
    #1;
    check("rst_rd_req_ready_wr_pending", 130'(rd_req_ready), 130'(0));
    wr_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full-line write then read-back.
    send_wr(8'h2A, FULL_DATA, 16'hFFFF, acc_w);
    send_rd(8'h2A, FULL_DATA, acc_r);
    drain();

    // Partial masks, including the empty mask.
    send_wr(8'h05, {16{8'hAA}}, 16'hFFFF, acc_w);
    send_wr(8'h05, {16{8'h55}}, 16'h000F, acc_w);
    send_rd(8'h05, {{12{8'hAA}}, {4{8'h55}}}, acc_r);
    send_wr(8'h05, {16{8'h00}}, 16'h0000, acc_w);
    send_rd(8'h05, {{12{8'hAA}}, {4{8'h55}}}, acc_r);
    send_wr(8'h06, {16{8'h00}}, 16'hFFFF, acc_w);
    send_wr(8'h06, {16{8'hFF}}, 16'h8001, acc_w);
    send_rd(8'h06, {8'hFF, {14{8'h00}}, 8'hFF}, acc_r);
    drain();

    // Address extremes.
    send_wr(8'h00, 128'h1, 16'hFFFF, acc_w);
    send_wr(8'hFF, {1'b1, 127'h0}, 16'hFFFF, acc_w);
    send_rd(8'h00, 128'h1, acc_r);
    send_rd(8'hFF, {1'b1, 127'h0}, acc_r);
    send_rd(8'h2A, FULL_DATA, acc_r);
    drain();

    // Simultaneous requests: write wins, read follows the write handshake.
    @(negedge clk);
    rd_req_valid = 1'b1;
    rd_req.addr  = 8'h10;
    wr_req_valid = 1'b1;
    wr_req.addr  = 8'h10;
    wr_req.data  = PRIO_DATA;
    wr_req.wmask = 16'hFFFF;
    #1;
    check("prio_rd_req_ready", 130'(rd_req_ready), 130'(0));
    check("prio_wr_req_ready", 130'(wr_req_ready), 130'(1));
    wait_wr_accept(acc_w);
    check("prio_state_after_accept", 130'(dbg_state), 130'(ST_WR_WAIT));
    wait_rd_accept(PRIO_DATA, acc_r);
    check("prio_rd_accept_cycle", 130'(acc_r), 130'(acc_w + WR_LAT + 2));
    drain();

    // Read response backpressure.
    send_wr(8'h40, BP_DATA, 16'hFFFF, acc_w);
    drain();
    rd_resp_ready = 1'b0;
    send_rd(8'h40, BP_DATA, acc_r);
    repeat (RD_LAT) @(negedge clk);
    rd_req_valid = 1'b1;
    rd_req.addr  = 8'h41;
    for (int i = 0; i < 10; i++) begin
      #3;
      check("bp_rd_resp_valid", 130'(rd_resp_valid), 130'(1));
      check("bp_rd_req_ready", 130'(rd_req_ready), 130'(0));
      check("bp_wr_req_ready", 130'(wr_req_ready), 130'(0));
      @(negedge clk);
    end
    rd_req_valid  = 1'b0;
    rd_resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_after_ready", 130'(dbg_state), 130'(ST_IDLE));
    check("bp_valid_dropped", 130'(rd_resp_valid), 130'(0));
    drain();

    // Reset in the middle of a write: the write must not land.
    send_wr(8'h33, {128{1'b0}}, 16'hFFFF, acc_w);
    drain();
    send_wr(8'h33, {128{1'b1}}, 16'hFFFF, acc_w);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_req_ready", 130'(wr_req_ready), 130'(1));
    check("midrst_state", 130'(dbg_state), 130'(ST_IDLE));
    check("midrst_wr_resp_valid", 130'(wr_resp_valid), 130'(0));
    check("midrst_rd_resp", rd_resp, 130'(0));
    exp_wr_q.delete();
    exp_wr_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    send_rd(8'h33, {128{1'b0}}, acc_r);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    fail_now("global_timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
